// File: rtl/linear_transfomation_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// linear_transfomation_cfg_ctrl
//
// Purpose:
//   Configuration sequencer for the piecewise-linear transform datapath. The
//   host fills a 16-entry shadow table of control points. On a commit request
//   the block waits for a frame boundary, copies the shadow table into the
//   active table in a single cycle, pulses cal_begin, and then waits for the
//   delta generator to report completion. o_lt_enable tells downstream logic
//   whether the deltas match the active table; while it is low the transform
//   output must be bypassed.
//
// Ports:
//   i_clock        single clock
//   i_rst_n        asynchronous active-low reset
//   i_wr_en        shadow table write strobe
//   i_wr_addr      shadow write index (0..15)
//   i_wr_data      control point value to write
//   i_rd_addr      shadow readback index
//   o_rd_data      registered shadow[i_rd_addr], one cycle of latency
//   i_commit       one-cycle request to apply the shadow table
//   i_frame_sync   one-cycle frame-boundary pulse
//   o_cal_begin    one-cycle start pulse to the delta generator
//   i_cal_valid    completion level from the delta generator
//   o_coef_bus     active table, C_k at [k*DSIZE +: DSIZE]
//   o_lt_enable    1 = deltas valid, transform output may be used
//   o_busy         high while a request is pending, loading or calculating
//   o_done         one-cycle pulse when a calculation completes
//   o_err_timeout  sticky timeout flag, cleared by the next success
// -----------------------------------------------------------------------------
module linear_transfomation_cfg_ctrl #(
    parameter int DSIZE  = 12,
    parameter int DM     = 16,
    parameter int TO_CYC = 256,
    parameter int CW     = 9
) (
    input  logic                  i_clock,
    input  logic                  i_rst_n,
    input  logic                  i_wr_en,
    input  logic [3:0]            i_wr_addr,
    input  logic [DSIZE-1:0]      i_wr_data,
    input  logic [3:0]            i_rd_addr,
    output logic [DSIZE-1:0]      o_rd_data,
    input  logic                  i_commit,
    input  logic                  i_frame_sync,
    output logic                  o_cal_begin,
    input  logic                  i_cal_valid,
    output logic [16*DSIZE-1:0]   o_coef_bus,
    output logic                  o_lt_enable,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err_timeout
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PEND = 2'd1;
    localparam logic [1:0] S_LOAD = 2'd2;
    localparam logic [1:0] S_WAIT = 2'd3;

    localparam logic [CW-1:0] TO_LAST = CW'(TO_CYC - 1);

    logic [DSIZE-1:0] r_shadow [16];
    logic [DSIZE-1:0] r_active [16];
    logic [DSIZE-1:0] r_rd_data;

    logic [1:0]       r_state;
    logic             r_pend_flag;
    logic             r_cal_valid_d;
    logic [CW-1:0]    r_to_cnt;
    logic             r_cal_begin;
    logic             r_lt_enable;
    logic             r_done;
    logic             r_err_timeout;

    logic             w_cv_rise;
    logic             w_copy;
    logic             w_wait_exit;

    // Only a rising edge of cal_valid counts as completion, so a level left
    // high from a previous calculation cannot complete a new one.
    assign w_cv_rise   = i_cal_valid & ~r_cal_valid_d;
    assign w_copy      = (r_state == S_PEND) && i_frame_sync;
    assign w_wait_exit = (r_state == S_WAIT) && (w_cv_rise || (r_to_cnt == TO_LAST));

    // Shadow and active tables. Both carry reset values, so they live in
    // flops rather than RAM. Because the copy reads r_shadow before this
    // cycle's write lands, a write coinciding with the copy reaches the
    // shadow only.
    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < 16; k++) begin
                r_shadow[k] <= DSIZE'(k * DM);
                r_active[k] <= DSIZE'(k * DM);
            end
            r_rd_data <= '0;
        end else begin
            if (i_wr_en) begin
                r_shadow[i_wr_addr] <= i_wr_data;
            end
            if (w_copy) begin
                for (int k = 0; k < 16; k++) begin
                    r_active[k] <= r_shadow[k];
                end
            end
            // Same-address read during a write returns the old value.
            r_rd_data <= r_shadow[i_rd_addr];
        end
    end

    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_pend_flag   <= 1'b0;
            r_cal_valid_d <= 1'b0;
            r_to_cnt      <= '0;
            r_cal_begin   <= 1'b0;
            r_lt_enable   <= 1'b0;
            r_done        <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_cal_valid_d <= i_cal_valid;
            r_cal_begin   <= 1'b0;
            r_done        <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    // A frame_sync arriving with the commit is not consumed.
                    if (i_commit) begin
                        r_state <= S_PEND;
                    end
                end

                S_PEND: begin
                    // Commits here merge into the request already queued.
                    if (w_copy) begin
                        r_state     <= S_LOAD;
                        r_cal_begin <= 1'b1;
                        // Active table is changing, the old deltas are stale.
                        r_lt_enable <= 1'b0;
                    end
                end

                S_LOAD: begin
                    r_lt_enable <= 1'b0;
                    r_to_cnt    <= '0;
                    r_state     <= S_WAIT;
                    if (i_commit) begin
                        r_pend_flag <= 1'b1;
                    end
                end

                default: begin // S_WAIT
                    if (w_cv_rise) begin
                        r_lt_enable   <= 1'b1;
                        r_done        <= 1'b1;
                        r_err_timeout <= 1'b0;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_err_timeout <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end

                    // A commit on the exit cycle is folded into the queued
                    // request so it is not lost.
                    if (w_wait_exit) begin
                        r_state     <= (r_pend_flag || i_commit) ? S_PEND : S_IDLE;
                        r_pend_flag <= 1'b0;
                    end else if (i_commit) begin
                        r_pend_flag <= 1'b1;
                    end
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_coef
            assign o_coef_bus[gi*DSIZE +: DSIZE] = r_active[gi];
        end
    endgenerate

    assign o_rd_data     = r_rd_data;
    assign o_cal_begin   = r_cal_begin;
    assign o_lt_enable   = r_lt_enable;
    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = r_done;
    assign o_err_timeout = r_err_timeout;

endmodule

// File: tb/tb_linear_transfomation_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_linear_transfomation_cfg_ctrl
//
// Directed bench for the configuration sequencer. Each task drives one
// scenario and checks outputs inline against hand-computed values. Inputs
// change 1 time unit after the rising edge and outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_linear_transfomation_cfg_ctrl;

    localparam int DSIZE  = 12;
    localparam int DM     = 16;
    localparam int TO_CYC = 256;
    localparam int CW     = 9;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 wr_en;
    logic [3:0]           wr_addr;
    logic [DSIZE-1:0]     wr_data;
    logic [3:0]           rd_addr;
    logic [DSIZE-1:0]     rd_data;
    logic                 commit;
    logic                 frame_sync;
    logic                 cal_begin;
    logic                 cal_valid;
    logic [16*DSIZE-1:0]  coef_bus;
    logic                 lt_enable;
    logic                 busy;
    logic                 done;
    logic                 err_timeout;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    linear_transfomation_cfg_ctrl #(
        .DSIZE(DSIZE), .DM(DM), .TO_CYC(TO_CYC), .CW(CW)
    ) dut (
        .i_clock       (clk),
        .i_rst_n       (rst_n),
        .i_wr_en       (wr_en),
        .i_wr_addr     (wr_addr),
        .i_wr_data     (wr_data),
        .i_rd_addr     (rd_addr),
        .o_rd_data     (rd_data),
        .i_commit      (commit),
        .i_frame_sync  (frame_sync),
        .o_cal_begin   (cal_begin),
        .i_cal_valid   (cal_valid),
        .o_coef_bus    (coef_bus),
        .o_lt_enable   (lt_enable),
        .o_busy        (busy),
        .o_done        (done),
        .o_err_timeout (err_timeout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DSIZE-1:0] coef(input int k);
        return coef_bus[k*DSIZE +: DSIZE];
    endfunction

    // Stimulus only: commit, then a frame_sync, leaving the DUT in LOAD.
    task automatic commit_and_sync();
        commit = 1'b1; step(); commit = 1'b0;
        frame_sync = 1'b1; step(); frame_sync = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_en = 0; wr_addr = 0; wr_data = 0; rd_addr = 0;
        commit = 0; frame_sync = 0; cal_valid = 0;
        step(); step();
        for (int k = 0; k < 16; k++) begin
            n_vec++;
            if (coef(k) !== DSIZE'(16 * k)) begin
                n_err++; $display("FAIL reset_coef[%0d] got %0d want %0d", k, coef(k), 16 * k);
            end
        end
        n_vec++; if (lt_enable !== 1'b0) begin n_err++; $display("FAIL reset_lt got %b want 0", lt_enable); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (rd_data !== 12'h000) begin n_err++; $display("FAIL reset_rd got %h want 000", rd_data); end
        n_vec++; if (done !== 1'b0 || cal_begin !== 1'b0 || err_timeout !== 1'b0) begin
            n_err++; $display("FAIL reset_pulses got done=%b cb=%b err=%b want 0", done, cal_begin, err_timeout);
        end
        rst_n = 1'b1; step();
        $display("test_reset complete");
    endtask

    task automatic test_basic();
        wr_en = 1; wr_addr = 3; wr_data = 12'h123; step(); wr_en = 0;
        commit = 1; step(); commit = 0;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy got %b want 1", busy); end
        for (int i = 0; i < 4; i++) step();
        n_vec++; if (coef(3) !== 12'h030) begin n_err++; $display("FAIL basic_pre_copy got %h want 030", coef(3)); end
        frame_sync = 1; step(); frame_sync = 0;
        n_vec++; if (coef(3) !== 12'h123) begin n_err++; $display("FAIL basic_copy got %h want 123", coef(3)); end
        n_vec++; if (cal_begin !== 1'b1) begin n_err++; $display("FAIL basic_cb_hi got %b want 1", cal_begin); end
        step();
        n_vec++; if (cal_begin !== 1'b0) begin n_err++; $display("FAIL basic_cb_lo got %b want 0", cal_begin); end
        n_vec++; if (lt_enable !== 1'b0) begin n_err++; $display("FAIL basic_lt_wait got %b want 0", lt_enable); end
        for (int i = 0; i < 8; i++) step();
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_early_done got %b want 0", done); end
        cal_valid = 1; step();
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL basic_done got %b want 1", done); end
        n_vec++; if (lt_enable !== 1'b1) begin n_err++; $display("FAIL basic_lt got %b want 1", lt_enable); end
        rd_addr = 3; step();
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse got %b want 0", done); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_idle got %b want 0", busy); end
        n_vec++; if (rd_data !== 12'h123) begin n_err++; $display("FAIL basic_readback got %h want 123", rd_data); end
        $display("test_basic complete");
    endtask

    task automatic test_timeout();
        bit saw_done = 0;
        bit ended = 0;
        // cal_valid is still high from the previous test: no new rising edge.
        commit_and_sync();
        for (int i = 0; i < 2 * TO_CYC; i++) begin
            step();
            if (done) saw_done = 1;
            if (!busy) begin ended = 1; break; end
        end
        n_vec++; if (ended !== 1'b1) begin n_err++; $display("FAIL to_return_idle got busy=%b want 0", busy); end
        n_vec++; if (err_timeout !== 1'b1) begin n_err++; $display("FAIL to_err got %b want 1", err_timeout); end
        n_vec++; if (lt_enable !== 1'b0) begin n_err++; $display("FAIL to_lt got %b want 0", lt_enable); end
        n_vec++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL to_done got %b want 0", saw_done); end
        cal_valid = 0; step();
        commit_and_sync(); step();
        cal_valid = 1; step();
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL to_retry_done got %b want 1", done); end
        n_vec++; if (err_timeout !== 1'b0) begin n_err++; $display("FAIL to_err_clear got %b want 0", err_timeout); end
        n_vec++; if (lt_enable !== 1'b1) begin n_err++; $display("FAIL to_retry_lt got %b want 1", lt_enable); end
        cal_valid = 0; step();
        $display("test_timeout complete");
    endtask

    task automatic test_pending();
        int n_cb = 0;
        commit_and_sync(); step();
        for (int i = 0; i < 3; i++) begin commit = 1; step(); commit = 0; step(); end
        cal_valid = 1; step();
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL pend_done got %b want 1", done); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL pend_busy got %b want 1", busy); end
        cal_valid = 0;
        for (int i = 0; i < 4; i++) begin step(); if (cal_begin) n_cb++; end
        n_vec++; if (n_cb !== 0) begin n_err++; $display("FAIL pend_cb_early got %0d want 0", n_cb); end
        frame_sync = 1; step(); frame_sync = 0;
        if (cal_begin) n_cb++;
        for (int i = 0; i < 5; i++) begin step(); if (cal_begin) n_cb++; end
        n_vec++; if (n_cb !== 1) begin n_err++; $display("FAIL pend_cb_count got %0d want 1", n_cb); end
        cal_valid = 1; step();
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL pend_done2 got %b want 1", done); end
        step();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL pend_idle got %b want 0", busy); end
        cal_valid = 0; step();
        $display("test_pending complete");
    endtask

    task automatic test_write_during_copy();
        commit = 1; step(); commit = 0;
        frame_sync = 1; wr_en = 1; wr_addr = 7; wr_data = 12'hABC; step();
        frame_sync = 0; wr_en = 0;
        n_vec++; if (coef(7) !== 12'h070) begin n_err++; $display("FAIL wdc_active got %h want 070", coef(7)); end
        rd_addr = 7; step(); step();
        n_vec++; if (rd_data !== 12'hABC) begin n_err++; $display("FAIL wdc_shadow got %h want abc", rd_data); end
        cal_valid = 1; step(); cal_valid = 0; step();
        $display("test_write_during_copy complete");
    endtask

    task automatic test_reset_mid();
        bit saw_done = 0;
        commit_and_sync(); step(); step();
        rst_n = 0; #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy got %b want 0", busy); end
        n_vec++; if (lt_enable !== 1'b0) begin n_err++; $display("FAIL rmid_lt got %b want 0", lt_enable); end
        n_vec++; if (coef(3) !== 12'h030) begin n_err++; $display("FAIL rmid_coef3 got %h want 030", coef(3)); end
        n_vec++; if (rd_data !== 12'h000) begin n_err++; $display("FAIL rmid_rd got %h want 000", rd_data); end
        step(); rst_n = 1; step();
        cal_valid = 1;
        for (int i = 0; i < 5; i++) begin step(); if (done) saw_done = 1; end
        n_vec++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL rmid_done got %b want 0", saw_done); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_idle got %b want 0", busy); end
        cal_valid = 0;
        $display("test_reset_mid complete");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_pending();
        test_write_during_copy();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
